// File: rtl/rtc_ciclo_bus.sv
// Bus-cycle sequencer for a multiplexed-AD RTC chip: address phase, data phase, one-cycle done pulse.
// Optional macro RTC_BCD_CHECK_EN adds error_bcd, flagging non-BCD bytes returned by read cycles.
module rtc_ciclo_bus #(
    parameter int T_PULSO  = 10,
    parameter int T_ESPERA = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       escritura,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escribir,
    input  logic [7:0] ad_entrada,
    output logic [7:0] ad_salida,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] dato_leido,
    output logic       listo,
    output logic       ocupado
`ifdef RTC_BCD_CHECK_EN
    ,
    output logic       error_bcd
`endif
);

    localparam int T_MAX = (T_PULSO > T_ESPERA) ? T_PULSO : T_ESPERA;
    localparam int CNT_W = $clog2(T_MAX) + 1;
    localparam logic [CNT_W-1:0] C_FIN_PULSO  = CNT_W'(T_PULSO - 1);
    localparam logic [CNT_W-1:0] C_FIN_ESPERA = CNT_W'(T_ESPERA - 1);

    typedef enum logic [2:0] {
        REPOSO,
        DIR_PULSO,
        DIR_ESPERA,
        DATO_PULSO,
        DATO_ESPERA,
        FIN
    } estado_t;

    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic             r_escritura;
    logic [7:0]       r_dato;
    logic [7:0]       r_ad_salida;
    logic             r_ad_oe;
    logic             r_cs_n;
    logic             r_rd_n;
    logic             r_wr_n;
    logic             r_a_d;
    logic [7:0]       r_dato_leido;
    logic             r_listo;
    logic             r_ocupado;
`ifdef RTC_BCD_CHECK_EN
    logic             r_error_bcd;
`endif

    logic w_fin_pulso;
    logic w_fin_espera;

    assign w_fin_pulso  = (r_cnt == C_FIN_PULSO);
    assign w_fin_espera = (r_cnt == C_FIN_ESPERA);

    // NOTE: every register, data included, takes the async reset so an aborted cycle leaves the bus idle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado     <= REPOSO;
            r_cnt        <= '0;
            r_escritura  <= 1'b0;
            r_dato       <= '0;
            r_ad_salida  <= '0;
            r_ad_oe      <= 1'b0;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_a_d        <= 1'b0;
            r_dato_leido <= '0;
            r_listo      <= 1'b0;
            r_ocupado    <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
            r_error_bcd  <= 1'b0;
`endif
        end else begin
            r_listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    r_cnt <= '0;
                    if (inicio) begin
                        r_estado    <= DIR_PULSO;
                        r_escritura <= escritura;
                        r_dato      <= dato_escribir;
                        r_ad_salida <= direccion;
                        r_ad_oe     <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_rd_n      <= 1'b1;
                        r_wr_n      <= 1'b0;
                        r_a_d       <= 1'b0;
                        r_ocupado   <= 1'b1;
`ifdef RTC_BCD_CHECK_EN
                        r_error_bcd <= 1'b0;
`endif
                    end
                end
                DIR_PULSO: begin
                    if (w_fin_pulso) begin
                        r_estado <= DIR_ESPERA;
                        r_cnt    <= '0;
                        r_cs_n   <= 1'b1;
                        r_wr_n   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DIR_ESPERA: begin
                    if (w_fin_espera) begin
                        r_estado <= DATO_PULSO;
                        r_cnt    <= '0;
                        r_cs_n   <= 1'b0;
                        r_a_d    <= 1'b1;
                        if (r_escritura) begin
                            r_wr_n      <= 1'b0;
                            r_ad_oe     <= 1'b1;
                            r_ad_salida <= r_dato;
                        end else begin
                            r_rd_n  <= 1'b0;
                            r_ad_oe <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATO_PULSO: begin
                    if (w_fin_pulso) begin
                        r_estado <= DATO_ESPERA;
                        r_cnt    <= '0;
                        r_cs_n   <= 1'b1;
                        r_rd_n   <= 1'b1;
                        r_wr_n   <= 1'b1;
                        r_ad_oe  <= r_escritura;
                        // Sampled on the edge that raises rd_n, so the chip is still driving the bus.
                        if (!r_escritura) begin
                            r_dato_leido <= ad_entrada;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATO_ESPERA: begin
                    if (w_fin_espera) begin
                        r_estado <= FIN;
                        r_cnt    <= '0;
                        r_listo  <= 1'b1;
                        r_ad_oe  <= 1'b0;
                        r_a_d    <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
                        if (!r_escritura) begin
                            r_error_bcd <= (r_dato_leido[7:4] > 4'd9) || (r_dato_leido[3:0] > 4'd9);
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    r_estado  <= REPOSO;
                    r_cnt     <= '0;
                    r_ocupado <= 1'b0;
                end
                default: begin
                    r_estado  <= REPOSO;
                    r_cnt     <= '0;
                    r_cs_n    <= 1'b1;
                    r_rd_n    <= 1'b1;
                    r_wr_n    <= 1'b1;
                    r_a_d     <= 1'b0;
                    r_ad_oe   <= 1'b0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign ad_salida  = r_ad_salida;
    assign ad_oe      = r_ad_oe;
    assign cs_n       = r_cs_n;
    assign rd_n       = r_rd_n;
    assign wr_n       = r_wr_n;
    assign a_d        = r_a_d;
    assign dato_leido = r_dato_leido;
    assign listo      = r_listo;
    assign ocupado    = r_ocupado;
`ifdef RTC_BCD_CHECK_EN
    assign error_bcd  = r_error_bcd;
`endif

endmodule

// File: tb/tb_rtc_ciclo_bus.sv
// Directed bench for rtc_ciclo_bus at T_PULSO=T_ESPERA=10: write, read, ignored restart, back-to-back, abort.
// Build with RTC_BCD_CHECK_EN defined to also check error_bcd.
module tb_rtc_ciclo_bus;

    logic       clk = 1'b0;
    logic       reset;
    logic       inicio;
    logic       escritura;
    logic [7:0] direccion;
    logic [7:0] dato_escribir;
    logic [7:0] ad_entrada;
    logic [7:0] ad_salida;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] dato_leido;
    logic       listo;
    logic       ocupado;
`ifdef RTC_BCD_CHECK_EN
    logic       error_bcd;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] model_dl = 8'h00;

    rtc_ciclo_bus #(.T_PULSO(10), .T_ESPERA(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio),
        .escritura     (escritura),
        .direccion     (direccion),
        .dato_escribir (dato_escribir),
        .ad_entrada    (ad_entrada),
        .ad_salida     (ad_salida),
        .ad_oe         (ad_oe),
        .cs_n          (cs_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .a_d           (a_d),
        .dato_leido    (dato_leido),
        .listo         (listo),
        .ocupado       (ocupado)
`ifdef RTC_BCD_CHECK_EN
        ,
        .error_bcd     (error_bcd)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bus vector layout: {cs_n, rd_n, wr_n, a_d, ad_oe, listo, ocupado, ad_salida, dato_leido}
    function automatic logic [22:0] bus_obs();
        return {cs_n, rd_n, wr_n, a_d, ad_oe, listo, ocupado, ad_salida, dato_leido};
    endfunction

    // Expected bus state k edges after the edge that sampled inicio (k=1 is that edge).
    function automatic void expect_at(input int k, input logic wr, input logic [7:0] addr,
                                      input logic [7:0] data, input logic [7:0] dl,
                                      output logic [22:0] e, output logic [22:0] m);
        m = '1;
        if (k <= 10) begin
            e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, addr, dl};
        end else if (k <= 20) begin
            e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, addr, dl};
        end else if (k <= 30) begin
            e = {1'b0, wr, ~wr, 1'b1, wr, 1'b0, 1'b1, wr ? data : 8'h00, dl};
            if (!wr) m[15:8] = 8'h00;
        end else if (k <= 40) begin
            e = {1'b1, 1'b1, 1'b1, 1'b1, wr, 1'b0, 1'b1, wr ? data : 8'h00, dl};
            if (!wr) m[15:8] = 8'h00;
        end else if (k == 41) begin
            e = {5'b00000, 1'b1, 1'b1, 8'h00, dl};
            m = {5'b00000, 1'b1, 1'b1, 8'h00, 8'hFF};
        end else begin
            e = {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, dl};
            m = {3'b111, 2'b00, 1'b1, 1'b1, 8'h00, 8'hFF};
        end
    endfunction

    // Caller has already driven inicio=1 and the request inputs; runs 42 edges checking every cycle.
    task automatic run_cycle(input string name, input logic wr, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] rdval, input int pulse_k);
        logic [22:0] e;
        logic [22:0] m;
        for (int k = 1; k <= 42; k++) begin
            tick();
            if (k == 1) begin
                inicio        = 1'b0;
                escritura     = ~wr;
                direccion     = ~addr;
                dato_escribir = ~data;
            end
            if (!wr && k == 31) model_dl = rdval;
            expect_at(k, wr, addr, data, model_dl, e, m);
            check($sformatf("%s_k%0d", name, k), 32'(bus_obs() & m), 32'(e & m));
`ifdef RTC_BCD_CHECK_EN
            if (k == 41) begin
                check($sformatf("%s_error_bcd", name), 32'(error_bcd),
                      32'(!wr && ((rdval[7:4] > 4'd9) || (rdval[3:0] > 4'd9))));
            end
`endif
            ad_entrada = (k == 30) ? rdval : ~rdval;
            if (pulse_k > 0 && k == pulse_k)     inicio = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) inicio = 1'b0;
        end
    endtask

    task automatic start(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        inicio        = 1'b1;
        escritura     = wr;
        direccion     = addr;
        dato_escribir = data;
    endtask

    initial begin
        reset         = 1'b0;
        inicio        = 1'b0;
        escritura     = 1'b0;
        direccion     = 8'h00;
        dato_escribir = 8'h00;
        ad_entrada    = 8'h00;

        tick();
        tick();
        check("reset_state", 32'(bus_obs()), 32'({7'b1110000, 8'h00, 8'h00}));

        #2 reset = 1'b1;
        tick();
        tick();
        check("idle_after_reset", 32'({listo, ocupado}), 32'(2'b00));

        // Write 0x59 to 0x05, with a spurious inicio sampled at clk 15.
        start(1'b1, 8'h05, 8'h59);
        run_cycle("wr05", 1'b1, 8'h05, 8'h59, 8'h00, 14);
        tick();
        tick();
        check("no_restart_after_pulse", 32'({listo, ocupado}), 32'(2'b00));

        // Read 0x23 from 0x04.
        start(1'b0, 8'h04, 8'h00);
        run_cycle("rd04", 1'b0, 8'h04, 8'h00, 8'h23, 0);

        // Back-to-back reads: inicio in the REPOSO cycle straight after FIN.
        start(1'b0, 8'h07, 8'h00);
        run_cycle("b2b_rd3A", 1'b0, 8'h07, 8'h00, 8'h3A, 0);
        start(1'b0, 8'h08, 8'h00);
        run_cycle("b2b_rd12", 1'b0, 8'h08, 8'h00, 8'h12, 0);
        start(1'b1, 8'h10, 8'h99);
        run_cycle("b2b_wr10", 1'b1, 8'h10, 8'h99, 8'h00, 0);
        check("dl_kept_by_write", 32'(dato_leido), 32'(8'h12));

        // Abort a read in the middle of DATO_PULSO.
        tick();
        start(1'b0, 8'h04, 8'h00);
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 1) inicio = 1'b0;
        end
        check("pre_abort_dato_pulso", 32'({cs_n, rd_n, a_d, ocupado}), 32'(4'b0011));
        #2 reset = 1'b0;
        #1;
        model_dl = 8'h00;
        check("abort_async", 32'(bus_obs()), 32'({7'b1110000, 8'h00, 8'h00}));
        inicio = 1'b1;
        tick();
        check("held_reset_ignores_inicio", 32'({listo, ocupado, cs_n}), 32'(3'b001));
        tick();
        check("held_reset_no_listo", 32'({listo, ocupado}), 32'(2'b00));
        #2 reset = 1'b1;
        escritura     = 1'b0;
        direccion     = 8'h0C;
        dato_escribir = 8'h00;
        run_cycle("post_reset_rd0C", 1'b0, 8'h0C, 8'h00, 8'h45, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
